// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified instruction/data memory between the
// IF stage (fetch) and the MEM stage (lw/sw). One requester is granted at a time.
// Each access runs ISSUE -> WAIT (LAT cycles) -> DONE, and ends with a one-cycle
// ready pulse alongside the registered read data.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   if_req/if_addr               fetch request (held until if_ready) and PC
//   if_ready/if_rdata            fetch-complete pulse and registered instruction word
//   d_read/d_write/d_addr/d_wdata  data request (held until d_ready), address, store data
//   d_ready/d_rdata              data-complete pulse and registered load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory port (registered)
//   mem_rdata                    memory read data, valid LAT cycles after mem_en
//   stall                        combinational pipeline stall
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;   // 0 = fetch, 1 = data
  logic              last_q, last_d;     // last requester served, same encoding
  logic              wr_q, wr_d;         // latched write enable of access in flight
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_req;

  // A simultaneous read+write is a write; the read half is dropped.
  assign d_req = d_read | d_write;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (d_req || if_req) begin
          // On a tie, serve whoever was not served last so fetch cannot starve.
          grant_d = d_req && (!if_req || !last_q);
          if (grant_d) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wr_d    = d_write;
          end else begin
            addr_d  = if_addr;
            wdata_d = '0;
            wr_d    = 1'b0;
          end
          // Registered strobe: high during the ISSUE cycle only.
          mem_en_d = 1'b1;
          mem_we_d = wr_d;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 4'(LAT);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // mem_rdata is valid this cycle; capture it and raise ready for DONE.
          last_d = grant_q;
          if (grant_q) begin
            d_ready_d = 1'b1;
            if (!wr_q) d_rdata_d = mem_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      last_q     <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 4'd0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. u0 uses LAT = 2, u1 (LAT = 1) shares all inputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_read, d_write;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we, stall;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready1, d_ready1, mem_en1, mem_we1, stall1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready1), .if_rdata(if_rdata1),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata), .stall(stall1)
  );

  // Leaves the bench at posedge+1 of the first cycle out of reset (cycle 0).
  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    if ({mem_en, mem_we, if_ready, d_ready, stall} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, if_ready, d_ready, stall});
    else n_pass++;
    n_chk++;
    if ({mem_addr, mem_wdata} !== 64'h0)
      $display("FAIL reset_port: got %h_%h want 0", mem_addr, mem_wdata);
    else n_pass++;
    n_chk++;
    if ({if_rdata, d_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h_%h want 0", if_rdata, d_rdata);
    else n_pass++;
    n_chk++;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h40; mem_rdata = 32'h8C22_0004;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (mem_en !== (c == 1))
        $display("FAIL fetch_mem_en c%0d: got %b want %b", c, mem_en, c == 1);
      else n_pass++;
      n_chk++;
      if (if_ready !== (c == 4))
        $display("FAIL fetch_if_ready c%0d: got %b want %b", c, if_ready, c == 4);
      else n_pass++;
      n_chk++;
      if (stall !== (c < 4))
        $display("FAIL fetch_stall c%0d: got %b want %b", c, stall, c < 4);
      else n_pass++;
      n_chk++;
      if (c == 1) begin
        if (mem_addr !== 32'h40 || mem_we !== 1'b0)
          $display("FAIL fetch_issue: got addr %h we %b want 00000040 0", mem_addr, mem_we);
        else n_pass++;
        n_chk++;
      end
      if (c >= 4) begin
        if (if_rdata !== 32'h8C22_0004)
          $display("FAIL fetch_rdata c%0d: got %h want 8c220004", c, if_rdata);
        else n_pass++;
        n_chk++;
      end
      @(posedge clk); #1;
      if (c + 1 == 5) if_req = 1'b0;
    end
  endtask

  task automatic test_tie();
    do_reset();
    if_req = 1'b1; if_addr = 32'h44; d_read = 1'b1; d_addr = 32'h200;
    mem_rdata = 32'hAAAA_0001;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      if (mem_en !== (c == 1 || c == 6 || c == 11))
        $display("FAIL tie_mem_en c%0d: got %b", c, mem_en);
      else n_pass++;
      n_chk++;
      if (d_ready !== (c == 4 || c == 14))
        $display("FAIL tie_d_ready c%0d: got %b", c, d_ready);
      else n_pass++;
      n_chk++;
      if (if_ready !== (c == 9))
        $display("FAIL tie_if_ready c%0d: got %b", c, if_ready);
      else n_pass++;
      n_chk++;
      if (c == 1 || c == 11) begin
        if (mem_addr !== 32'h200)
          $display("FAIL tie_data_addr c%0d: got %h want 00000200", c, mem_addr);
        else n_pass++;
        n_chk++;
      end
      if (c == 6) begin
        if (mem_addr !== 32'h44)
          $display("FAIL tie_fetch_addr: got %h want 00000044", mem_addr);
        else n_pass++;
        n_chk++;
      end
      if (c == 4 || c == 9) begin
        if (d_rdata !== 32'hAAAA_0001)
          $display("FAIL tie_d_rdata c%0d: got %h want aaaa0001", c, d_rdata);
        else n_pass++;
        n_chk++;
      end
      if (c == 9) begin
        if (if_rdata !== 32'hBBBB_0002)
          $display("FAIL tie_if_rdata: got %h want bbbb0002", if_rdata);
        else n_pass++;
        n_chk++;
      end
      if (c == 14) begin
        if (d_rdata !== 32'hBBBB_0002)
          $display("FAIL tie_d_rdata2: got %h want bbbb0002", d_rdata);
        else n_pass++;
        n_chk++;
      end
      @(posedge clk); #1;
      if (c + 1 == 5) mem_rdata = 32'hBBBB_0002;
      if (c + 1 == 11) begin
        if_req = 1'b0; d_read = 1'b0;
      end
    end
  endtask

  // Runs straight after test_tie without reset, so d_rdata starts at bbbb0002.
  task automatic test_store();
    d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h1234_5678;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (mem_en !== (c == 1) || mem_we !== (c == 1))
        $display("FAIL store_en_we c%0d: got %b%b", c, mem_en, mem_we);
      else n_pass++;
      n_chk++;
      if (d_ready !== (c == 4))
        $display("FAIL store_d_ready c%0d: got %b want %b", c, d_ready, c == 4);
      else n_pass++;
      n_chk++;
      if (c == 1) begin
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF)
          $display("FAIL store_port: got %h %h want 00000100 deadbeef", mem_addr, mem_wdata);
        else n_pass++;
        n_chk++;
      end
      if (c >= 4) begin
        if (d_rdata !== 32'hBBBB_0002)
          $display("FAIL store_d_rdata c%0d: got %h want bbbb0002", c, d_rdata);
        else n_pass++;
        n_chk++;
      end
      @(posedge clk); #1;
      if (c + 1 == 5) d_write = 1'b0;
    end
  endtask

  task automatic test_read_write();
    do_reset();
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'h55;
    mem_rdata = 32'h7777_7777;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (mem_en !== (c == 1))
        $display("FAIL rw_mem_en c%0d: got %b want %b", c, mem_en, c == 1);
      else n_pass++;
      n_chk++;
      if (c == 1) begin
        if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h55)
          $display("FAIL rw_issue: got we %b addr %h data %h want 1 00000020 00000055",
                   mem_we, mem_addr, mem_wdata);
        else n_pass++;
        n_chk++;
      end
      if (c == 4) begin
        if (d_ready !== 1'b1 || d_rdata !== 32'h0)
          $display("FAIL rw_done: got ready %b rdata %h want 1 00000000", d_ready, d_rdata);
        else n_pass++;
        n_chk++;
      end
      @(posedge clk); #1;
      if (c + 1 == 5) begin
        d_read = 1'b0; d_write = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1'b1; if_addr = 32'h80; mem_rdata = 32'h1111_2222;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (if_ready !== (c == 7))
        $display("FAIL rstmid_if_ready c%0d: got %b want %b", c, if_ready, c == 7);
      else n_pass++;
      n_chk++;
      if (mem_en !== (c == 1 || c == 4))
        $display("FAIL rstmid_mem_en c%0d: got %b", c, mem_en);
      else n_pass++;
      n_chk++;
      if (c == 3) begin
        if ({mem_we, d_ready, mem_addr, if_rdata} !== 66'h0 || stall !== 1'b1)
          $display("FAIL rstmid_clear: got we %b addr %h rdata %h stall %b want 0 0 0 1",
                   mem_we, mem_addr, if_rdata, stall);
        else n_pass++;
        n_chk++;
      end
      if (c == 4) begin
        if (mem_addr !== 32'h80)
          $display("FAIL rstmid_restart_addr: got %h want 00000080", mem_addr);
        else n_pass++;
        n_chk++;
      end
      if (c == 7) begin
        if (if_rdata !== 32'h1111_2222)
          $display("FAIL rstmid_rdata: got %h want 11112222", if_rdata);
        else n_pass++;
        n_chk++;
      end
      @(posedge clk); #1;
      if (c + 1 == 2) rst = 1'b1;
      if (c + 1 == 3) rst = 1'b0;
      if (c + 1 == 8) if_req = 1'b0;
    end
  endtask

  task automatic test_drop();
    do_reset();
    if_req = 1'b1; if_addr = 32'h90; mem_rdata = 32'h3333_4444;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (if_ready !== (c == 4))
        $display("FAIL drop_if_ready c%0d: got %b want %b", c, if_ready, c == 4);
      else n_pass++;
      n_chk++;
      if (if_ready1 !== (c == 3))
        $display("FAIL drop_lat1_if_ready c%0d: got %b want %b", c, if_ready1, c == 3);
      else n_pass++;
      n_chk++;
      if (mem_en !== (c == 1))
        $display("FAIL drop_mem_en c%0d: got %b want %b", c, mem_en, c == 1);
      else n_pass++;
      n_chk++;
      if (stall !== (c < 2))
        $display("FAIL drop_stall c%0d: got %b want %b", c, stall, c < 2);
      else n_pass++;
      n_chk++;
      if (c == 3) begin
        if (if_rdata1 !== 32'h3333_4444)
          $display("FAIL drop_lat1_rdata: got %h want 33334444", if_rdata1);
        else n_pass++;
        n_chk++;
      end
      if (c == 4) begin
        if (if_rdata !== 32'h3333_4444)
          $display("FAIL drop_rdata: got %h want 33334444", if_rdata);
        else n_pass++;
        n_chk++;
      end
      @(posedge clk); #1;
      if (c + 1 == 2) if_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_tie();
    test_store();
    test_read_write();
    test_reset_mid();
    test_drop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
